// File: rtl/gen_scheduler.sv
// Generation scheduler for the 8x8 Life datapath: seed load, run/step
// pacing and automatic halt on extinction, still life or period-2 cycle.
// Ports:
//   in : clk, reset_n, runSwitch, stepBtn, loadSeed, randSel, gridIn[63:0]
//   out: loadGrid, seedSel, advance, lfsrEn, halted,
//        extinct, stable, osc2, genCount[15:0]
module gen_scheduler #(
  parameter int TICK_DIV = 12_500_000,
  parameter int CNT_W    = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        runSwitch,
  input  logic        stepBtn,
  input  logic        loadSeed,
  input  logic        randSel,
  input  logic [63:0] gridIn,
  output logic        loadGrid,
  output logic        seedSel,
  output logic        advance,
  output logic        lfsrEn,
  output logic        halted,
  output logic        extinct,
  output logic        stable,
  output logic        osc2,
  output logic [15:0] genCount
);

  localparam logic [CNT_W-1:0] TOP = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] PRE = CNT_W'(TICK_DIV - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_RUN,
    S_EVAL,
    S_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             adv_q, adv_d;
  logic             run_q, run_d;
  logic             pend_q, pend_d;
  logic [63:0]      h1_q, h1_d;
  logic [63:0]      h2_q, h2_d;
  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic [15:0]      gen_q, gen_d;
  logic             seed_q, seed_d;
  logic             ext_q, ext_d;
  logic             stb_q, stb_d;
  logic             osc_q, osc_d;
  logic             is_ext, is_stb, is_osc;

  assign cnt_inc = (cnt_q == TOP) ? '0 : cnt_q + 1'b1;
  assign is_ext  = (gridIn == 64'd0);
  assign is_stb  = v1_q & (gridIn == h1_q);
  assign is_osc  = v2_q & (gridIn == h2_q);

  // The advance pulse is decided one cycle ahead (at count TICK_DIV-2) so
  // it is registered and lines up with count TICK_DIV-1. Once advance is
  // high the grid has moved, so EVAL always follows; a loadSeed seen in
  // that cycle is deferred through the pending bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adv_d   = 1'b0;
    run_d   = run_q;
    pend_d  = pend_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    gen_d   = gen_q;
    seed_d  = seed_q;
    ext_d   = ext_q;
    stb_d   = stb_q;
    osc_d   = osc_q;

    if (adv_q) begin
      h2_d = h1_q;
      h1_d = gridIn;
      v2_d = v1_q;
      v1_d = 1'b1;
      if (gen_q != 16'hFFFF) gen_d = gen_q + 16'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (loadSeed) state_d = S_LOAD;
      end
      S_LOAD: begin
        seed_d  = randSel;
        gen_d   = '0;
        ext_d   = 1'b0;
        stb_d   = 1'b0;
        osc_d   = 1'b0;
        v1_d    = 1'b0;
        v2_d    = 1'b0;
        pend_d  = 1'b0;
        state_d = S_READY;
      end
      S_READY: begin
        if (adv_q) begin
          state_d = S_EVAL;
          if (loadSeed) pend_d = 1'b1;
        end else if (loadSeed) begin
          state_d = S_LOAD;
        end else if (stepBtn) begin
          adv_d = 1'b1;
          run_d = 1'b0;
        end else if (runSwitch) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (adv_q) begin
          state_d = S_EVAL;
          if (loadSeed) pend_d = 1'b1;
        end else if (loadSeed) begin
          state_d = S_LOAD;
        end else if (!runSwitch) begin
          state_d = S_READY;
        end else if (cnt_q == PRE) begin
          adv_d = 1'b1;
          run_d = 1'b1;
        end
      end
      S_EVAL: begin
        cnt_d = cnt_inc;
        if (pend_q | loadSeed) begin
          state_d = S_LOAD;
        end else if (is_ext | is_stb | is_osc) begin
          state_d = S_HALT;
          ext_d   = is_ext;
          stb_d   = is_stb;
          osc_d   = is_osc;
        end else if (run_q & runSwitch) begin
          state_d = S_RUN;
          // Only reachable with TICK_DIV == 2: the tick falls in EVAL.
          if (cnt_q == PRE) begin
            adv_d = 1'b1;
            run_d = 1'b1;
          end
        end else begin
          state_d = S_READY;
        end
      end
      S_HALT: begin
        if (loadSeed) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adv_q   <= 1'b0;
      run_q   <= 1'b0;
      pend_q  <= 1'b0;
      h1_q    <= '0;
      h2_q    <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      gen_q   <= '0;
      seed_q  <= 1'b0;
      ext_q   <= 1'b0;
      stb_q   <= 1'b0;
      osc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adv_q   <= adv_d;
      run_q   <= run_d;
      pend_q  <= pend_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      gen_q   <= gen_d;
      seed_q  <= seed_d;
      ext_q   <= ext_d;
      stb_q   <= stb_d;
      osc_q   <= osc_d;
    end
  end

  assign loadGrid = (state_q == S_LOAD);
  assign advance  = adv_q;
  assign halted   = (state_q == S_HALT);
  assign lfsrEn   = (state_q == S_IDLE) | (state_q == S_READY) |
                    (state_q == S_HALT);
  assign seedSel  = seed_q;
  assign extinct  = ext_q;
  assign stable   = stb_q;
  assign osc2     = osc_q;
  assign genCount = gen_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// Bench for gen_scheduler: scenario tasks plus random soups checked
// against a generation-list model of the Life game.
module tb_gen_scheduler;

  localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0102;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
  localparam logic [63:0] BLINKER = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] SINGLE  = 64'h0000_0010_0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        runSwitch;
  logic        stepBtn;
  logic        loadSeed;
  logic        randSel;
  logic [63:0] gridIn;
  logic        loadGrid;
  logic        seedSel;
  logic        advance;
  logic        lfsrEn;
  logic        halted;
  logic        extinct;
  logic        stable;
  logic        osc2;
  logic [15:0] genCount;

  int total = 0;
  int bad = 0;
  int adv_total = 0;

  logic [63:0] grid_q = '0;
  logic [63:0] seed_m = '0;
  logic [63:0] gens[$];

  gen_scheduler #(.TICK_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .runSwitch(runSwitch),
    .stepBtn(stepBtn), .loadSeed(loadSeed), .randSel(randSel),
    .gridIn(gridIn), .loadGrid(loadGrid), .seedSel(seedSel),
    .advance(advance), .lfsrEn(lfsrEn), .halted(halted),
    .extinct(extinct), .stable(stable), .osc2(osc2),
    .genCount(genCount)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 &&
                c + dc >= 0 && c + dc < 8) begin
              if (g[(r + dr) * 8 + c + dc]) cnt++;
            end
          end
        end
        n[r * 8 + c] = (cnt == 3) || (g[r * 8 + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  // {extinct, stable, osc2} predicted from the list of generations since load
  function automatic logic [2:0] exp_flags();
    int n;
    logic [63:0] last;
    logic [2:0] f;
    n = gens.size() - 1;
    last = gens[n];
    f = 3'b000;
    f[2] = (last == 64'd0);
    if (n >= 1) f[1] = (last == gens[n - 1]);
    if (n >= 2) f[0] = (last == gens[n - 2]);
    return f;
  endfunction

  // grid register stand-in
  assign gridIn = grid_q;
  always @(posedge clk) begin
    if (loadGrid) grid_q <= seed_m;
    else if (advance) grid_q <= life(grid_q);
  end

  always @(negedge clk) begin
    if (advance === 1'b1) adv_total++;
  end

  task automatic do_load(input logic [63:0] s, input logic rs);
    @(negedge clk);
    seed_m = s;
    randSel = rs;
    loadSeed = 1'b1;
    @(negedge clk);
    loadSeed = 1'b0;
    @(negedge clk);
    randSel = 1'b0;
    gens.delete();
    gens.push_back(s);
  endtask

  // step from READY; returns advance as seen in the cycle after the pulse
  task automatic do_step(output logic adv);
    @(negedge clk);
    stepBtn = 1'b1;
    @(negedge clk);
    stepBtn = 1'b0;
    adv = advance;
    gens.push_back(life(gens[gens.size() - 1]));
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int a0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({loadGrid, advance, seedSel, halted, extinct, stable, osc2} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outs: got %b want 0000000",
               {loadGrid, advance, seedSel, halted, extinct, stable, osc2});
    end
    total++;
    if (lfsrEn !== 1'b1) begin
      bad++;
      $display("FAIL reset_lfsr: got %b want 1", lfsrEn);
    end
    total++;
    if (genCount !== 16'd0) begin
      bad++;
      $display("FAIL reset_gen: got %0d want 0", genCount);
    end
    reset_n = 1'b1;
    a0 = adv_total;
    @(negedge clk);
    stepBtn = 1'b1;
    runSwitch = 1'b1;
    @(negedge clk);
    stepBtn = 1'b0;
    repeat (8) @(negedge clk);
    runSwitch = 1'b0;
    total++;
    if (adv_total !== a0 || lfsrEn !== 1'b1) begin
      bad++;
      $display("FAIL idle_ignore: adv=%0d lfsr=%b want adv=%0d lfsr=1",
               adv_total, lfsrEn, a0);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    seed_m = GLIDER;
    randSel = 1'b1;
    loadSeed = 1'b1;
    @(negedge clk);
    loadSeed = 1'b0;
    total++;
    if (loadGrid !== 1'b1 || advance !== 1'b0) begin
      bad++;
      $display("FAIL load_pulse: loadGrid=%b adv=%b want 1 0", loadGrid, advance);
    end
    @(negedge clk);
    randSel = 1'b0;
    total++;
    if (loadGrid !== 1'b0) begin
      bad++;
      $display("FAIL load_width: loadGrid=%b want 0", loadGrid);
    end
    total++;
    if (seedSel !== 1'b1 || genCount !== 16'd0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL load_state: seedSel=%b gen=%0d halted=%b want 1 0 0",
               seedSel, genCount, halted);
    end
    gens.delete();
    gens.push_back(GLIDER);
  endtask

  task automatic test_run_pacing();
    int hits[$];
    int got;
    int a0;
    logic [2:0] f;
    do_load(GLIDER, 1'b1);
    @(negedge clk);
    runSwitch = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (advance === 1'b1) begin
        hits.push_back(k);
        gens.push_back(life(gens[gens.size() - 1]));
      end
      if (k == 2) begin
        total++;
        if (lfsrEn !== 1'b0) begin
          bad++;
          $display("FAIL run_lfsr: got %b want 0", lfsrEn);
        end
      end
    end
    runSwitch = 1'b0;
    a0 = adv_total;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      got = (i < hits.size()) ? hits[i] : -1;
      if (got != 4 * (i + 1)) begin
        bad++;
        $display("FAIL run_tick%0d: cycle %0d want %0d", i, got, 4 * (i + 1));
      end
    end
    total++;
    if (hits.size() != 3 || adv_total != a0) begin
      bad++;
      $display("FAIL run_count: hits=%0d extra=%0d want 3 0",
               hits.size(), adv_total - a0);
    end
    f = exp_flags();
    total++;
    if (genCount !== 16'd3 || halted !== (|f)) begin
      bad++;
      $display("FAIL run_gen: gen=%0d halted=%b want 3 %b", genCount, halted, |f);
    end
  endtask

  task automatic test_still_life();
    logic a;
    int a0;
    do_load(BLOCK, 1'b0);
    total++;
    if (seedSel !== 1'b0) begin
      bad++;
      $display("FAIL still_seedsel: got %b want 0", seedSel);
    end
    do_step(a);
    total++;
    if (a !== 1'b1) begin
      bad++;
      $display("FAIL still_adv: got %b want 1", a);
    end
    total++;
    if ({halted, extinct, stable, osc2} !== 4'b1010 || genCount !== 16'd1) begin
      bad++;
      $display("FAIL still_halt: hesO=%b gen=%0d want 1010 1",
               {halted, extinct, stable, osc2}, genCount);
    end
    a0 = adv_total;
    @(negedge clk);
    stepBtn = 1'b1;
    @(negedge clk);
    stepBtn = 1'b0;
    runSwitch = 1'b1;
    repeat (8) @(negedge clk);
    runSwitch = 1'b0;
    total++;
    if (adv_total != a0 || halted !== 1'b1 || lfsrEn !== 1'b1) begin
      bad++;
      $display("FAIL halt_ignore: adv=%0d halted=%b lfsr=%b want %0d 1 1",
               adv_total, halted, lfsrEn, a0);
    end
  endtask

  task automatic test_oscillator();
    logic a;
    do_load(BLINKER, 1'b0);
    do_step(a);
    total++;
    if (a !== 1'b1 || halted !== 1'b0 || genCount !== 16'd1) begin
      bad++;
      $display("FAIL osc_step1: adv=%b halted=%b gen=%0d want 1 0 1",
               a, halted, genCount);
    end
    do_step(a);
    total++;
    if ({halted, extinct, stable, osc2} !== 4'b1001 || genCount !== 16'd2) begin
      bad++;
      $display("FAIL osc_step2: hesO=%b gen=%0d want 1001 2",
               {halted, extinct, stable, osc2}, genCount);
    end
  endtask

  task automatic test_extinct();
    logic a;
    do_load(SINGLE, 1'b0);
    do_step(a);
    total++;
    if ({halted, extinct, stable, osc2} !== 4'b1100 || genCount !== 16'd1) begin
      bad++;
      $display("FAIL extinct: hesO=%b gen=%0d want 1100 1",
               {halted, extinct, stable, osc2}, genCount);
    end
  endtask

  task automatic test_priority();
    int a0;
    do_load(BLINKER, 1'b0);
    a0 = adv_total;
    @(negedge clk);
    loadSeed = 1'b1;
    stepBtn = 1'b1;
    @(negedge clk);
    loadSeed = 1'b0;
    stepBtn = 1'b0;
    total++;
    if (loadGrid !== 1'b1 || advance !== 1'b0) begin
      bad++;
      $display("FAIL prio_load_step: loadGrid=%b adv=%b want 1 0", loadGrid, advance);
    end
    repeat (4) @(negedge clk);
    total++;
    if (adv_total != a0 || genCount !== 16'd0) begin
      bad++;
      $display("FAIL prio_no_adv: adv=%0d gen=%0d want %0d 0",
               adv_total, genCount, a0);
    end
    do_load(BLOCK, 1'b0);
    @(negedge clk);
    stepBtn = 1'b1;
    @(negedge clk);
    stepBtn = 1'b0;
    @(negedge clk);
    loadSeed = 1'b1;
    @(negedge clk);
    loadSeed = 1'b0;
    total++;
    if (loadGrid !== 1'b1 || halted !== 1'b0 || stable !== 1'b0) begin
      bad++;
      $display("FAIL prio_eval_load: loadGrid=%b halted=%b stable=%b want 1 0 0",
               loadGrid, halted, stable);
    end
    @(negedge clk);
    total++;
    if (halted !== 1'b0 || stable !== 1'b0 || genCount !== 16'd0) begin
      bad++;
      $display("FAIL prio_after: halted=%b stable=%b gen=%0d want 0 0 0",
               halted, stable, genCount);
    end
    gens.delete();
    gens.push_back(BLOCK);
  endtask

  task automatic test_random_step();
    logic a;
    logic [2:0] f;
    logic [63:0] s;
    for (int t = 0; t < 6; t++) begin
      s = {$urandom(), $urandom()} & {$urandom(), $urandom()};
      do_load(s, 1'($urandom_range(1)));
      for (int i = 0; i < 20; i++) begin
        do_step(a);
        f = exp_flags();
        total++;
        if (a !== 1'b1 || halted !== (|f) ||
            {extinct, stable, osc2} !== f ||
            genCount !== 16'(gens.size() - 1)) begin
          bad++;
          $display("FAIL rstep t%0d i%0d: adv=%b h=%b eso=%b gen=%0d want 1 %b %b %0d",
                   t, i, a, halted, {extinct, stable, osc2}, genCount,
                   |f, f, gens.size() - 1);
        end
        if (|f) break;
      end
    end
  endtask

  task automatic test_random_run();
    int waited;
    logic seen;
    logic [2:0] f;
    for (int t = 0; t < 3; t++) begin
      do_load({$urandom(), $urandom()} & {$urandom(), $urandom()}, 1'b1);
      @(negedge clk);
      runSwitch = 1'b1;
      for (int n = 0; n < 12; n++) begin
        waited = 0;
        seen = 1'b0;
        while (!seen && waited < 8) begin
          @(negedge clk);
          waited++;
          seen = (advance === 1'b1);
        end
        total++;
        if (!seen || waited != ((n == 0) ? 4 : 2)) begin
          bad++;
          $display("FAIL rrun_tick t%0d n%0d: seen=%b waited=%0d want 1 %0d",
                   t, n, seen, waited, (n == 0) ? 4 : 2);
          break;
        end
        gens.push_back(life(gens[gens.size() - 1]));
        @(negedge clk);
        @(negedge clk);
        f = exp_flags();
        total++;
        if (halted !== (|f) || {extinct, stable, osc2} !== f ||
            lfsrEn !== (|f) || genCount !== 16'(gens.size() - 1)) begin
          bad++;
          $display("FAIL rrun_eval t%0d n%0d: h=%b eso=%b lfsr=%b gen=%0d want %b %b %b %0d",
                   t, n, halted, {extinct, stable, osc2}, lfsrEn, genCount,
                   |f, f, |f, gens.size() - 1);
        end
        if (|f) break;
      end
      runSwitch = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_run();
    logic a;
    int a0;
    do_load(GLIDER, 1'b1);
    do_step(a);
    @(negedge clk);
    runSwitch = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({loadGrid, advance, seedSel, halted, extinct, stable, osc2} !== 7'b0 ||
        genCount !== 16'd0 || lfsrEn !== 1'b1) begin
      bad++;
      $display("FAIL midrun_reset: outs=%b gen=%0d lfsr=%b want 0000000 0 1",
               {loadGrid, advance, seedSel, halted, extinct, stable, osc2},
               genCount, lfsrEn);
    end
    a0 = adv_total;
    repeat (3) @(negedge clk);
    runSwitch = 1'b0;
    total++;
    if (adv_total != a0 || loadGrid !== 1'b0) begin
      bad++;
      $display("FAIL midrun_trail: adv=%0d loadGrid=%b want %0d 0",
               adv_total, loadGrid, a0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    stepBtn = 1'b1;
    @(negedge clk);
    stepBtn = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (adv_total != a0 || lfsrEn !== 1'b1) begin
      bad++;
      $display("FAIL midrun_idle: adv=%0d lfsr=%b want %0d 1",
               adv_total, lfsrEn, a0);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    runSwitch = 1'b0;
    stepBtn = 1'b0;
    loadSeed = 1'b0;
    randSel = 1'b0;
    test_reset();
    test_load();
    test_run_pacing();
    test_still_life();
    test_oscillator();
    test_extinct();
    test_priority();
    test_random_step();
    test_random_run();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
